decode_hazard_controller: RTL and testbench
===========================================

// Module: decode_hazard_controller
// PURPOSE
//  Scoreboard/sequencer for the instruction-decode stage. Tracks in-flight destination registers with
//  per-entry latency countdowns, stalls ID on RAW/WAW hazards, drives the 2-bit branch-forwarding
//  select of the branch compare muxes, and sequences the pipeline flush after a taken branch.
// PARAMETERS
//  REG_W        7   register specifier width (128-entry register file)
//  DEPTH        8   in-flight scoreboard entries
//  LAT_W        3   width of id_latency
//  MAX_LAT      7   largest legal id_latency (1..MAX_LAT)
//  FLUSH_CYCLES 1   cycles flush is held after a taken branch (>=1)
// PORTS
//  clk              in   1      clock, all state on rising edge
//  reset            in   1      asynchronous, active-low; clears all state
//  id_valid         in   1      valid instruction in ID
//  id_ra/id_rb/id_rc in  REG_W  source specifiers
//  id_uses_ra/rb/rc in   1      source actually read
//  id_is_branch     in   1      ID instruction is a compare-branch (uses RA,RB in branch compare)
//  id_writes_rt     in   1      ID instruction writes id_rt
//  id_rt            in   REG_W  destination specifier
//  id_latency       in   LAT_W  cycles from issue to writeback, 1..MAX_LAT
//  branch_result    in   1      branch gate output for the ID instruction
//  stall            out  1      hold PC and IF/ID register
//  flush            out  1      squash IF/ID contents
//  issue            out  1      ID instruction accepted this cycle
//  branch_fwd_sel   out  2      bit0: RA compare operand, bit1: RB; 0=register file, 1=memory-stage result
//  inflight_count   out  $clog2(DEPTH+1) valid scoreboard entries
// BEHAVIOUR
//  Reset: all entries invalid, FSM=RUN; stall=0, flush=0, issue=0, branch_fwd_sel=0, inflight_count=0.
//  Entry = {valid, reg, rem}. Every edge: valid entry with rem==1 retires (valid<=0); else rem<=rem-1.
//  Match(src) = valid && reg==src && uses_src. rem==1 means result is on the memory-stage bus.
//  RAW: any match with rem>=2 -> stall. Match with rem==1: branch RA/RB -> set branch_fwd_sel bit;
//   non-branch sources -> no action (EX-stage forwarding covers it).
//  WAW: id_writes_rt and existing entry for id_rt with rem>id_latency -> stall.
//  Full: id_writes_rt and no free entry (after this edge's retirements) -> stall.
//  branch_fwd_sel forced 0 when stall=1 or id_is_branch=0.
//  FSM states RUN, FLUSH (all outputs combinational from state + inputs, 0-cycle latency):
//   RUN:   issue = id_valid && !stall. On issue && id_writes_rt, allocate lowest free entry,
//          rem<=id_latency. Allocation and retirement of the same reg on one edge: new entry kept.
//          issue && id_is_branch && branch_result -> FLUSH, counter<=FLUSH_CYCLES.
//          branch_result ignored while stall=1 (compare operands not yet valid).
//   FLUSH: flush=1, stall=0, issue=0, id_valid ignored, no allocation; entries still count down;
//          counter decrements, counter==1 -> RUN.
//  id_latency=0 or >MAX_LAT is illegal (assertion); treated as 1.
//  Reset asserted mid-operation: immediate clear, pending flush abandoned, state RUN on release.
//  inflight_count registered: count of valid entries after each edge.
// CONFIGURATION
//  HAZARD_STATS_EN defined: extra output stall_cycles [15:0], increments every cycle stall=1,
//   saturates at 16'hFFFF, cleared by reset. Not defined: port and counter absent; all else identical.
// TESTING
//  1. Reset low with 3 entries valid -> inflight_count=0, stall=0, flush=0 asynchronously.
//  2. Issue R5 lat=4; next: non-branch reads R5 as RA -> stall=1 for 3 cycles, issue on 4th cycle.
//  3. Issue R5 lat=1; next: branch reads RA=R5 -> stall=0, branch_fwd_sel=2'b01, issue=1.
//  4. R7 in flight rem=5; writer R7 lat=2 (no R7 source) -> stall 3 cycles, issues when rem=2.
//  5. Branch issues with branch_result=1, FLUSH_CYCLES=2 -> flush=1 two cycles, id_valid ignored, then RUN.
//  6. HAZARD_STATS_EN: hold stall 70000 cycles -> stall_cycles=16'hFFFF, stays there.

Source files
------------

// File: rtl/decode_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_controller
// Brief    : ID-stage scoreboard. Tracks in-flight destinations with latency
//            countdowns, stalls on RAW/WAW/full and drives branch forwarding.
//            It also sequences the flush that follows a taken branch.
//            Optional: HAZARD_STATS_EN adds a saturating stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module decode_hazard_controller #(
  parameter int REG_W        = 7,
  parameter int DEPTH        = 8,
  parameter int LAT_W        = 3,
  parameter int MAX_LAT      = 7,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_ra,
  input  logic [REG_W-1:0]             id_rb,
  input  logic [REG_W-1:0]             id_rc,
  input  logic                         id_uses_ra,
  input  logic                         id_uses_rb,
  input  logic                         id_uses_rc,
  input  logic                         id_is_branch,
  input  logic                         id_writes_rt,
  input  logic [REG_W-1:0]             id_rt,
  input  logic [LAT_W-1:0]             id_latency,
  input  logic                         branch_result,
  output logic                         stall,
  output logic                         flush,
  output logic                         issue,
  output logic [1:0]                   branch_fwd_sel,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam int              CNT_W     = $clog2(DEPTH + 1);
  localparam int              FC_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [LAT_W:0]  MAX_LAT_X = (LAT_W + 1)'(MAX_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [REG_W-1:0]   reg_q [DEPTH];
  logic [REG_W-1:0]   reg_d [DEPTH];
  logic [LAT_W-1:0]   rem_q [DEPTH];
  logic [LAT_W-1:0]   rem_d [DEPTH];
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic               lat_legal;
  logic [LAT_W-1:0]   lat_eff;
  logic               raw_hit, waw_hit, free_found, hazard;
  logic [1:0]         fwd_hit;
  logic [DEPTH-1:0]   alloc_oh;

  always_comb begin
    lat_legal  = (id_latency != '0) && ({1'b0, id_latency} <= MAX_LAT_X);
    lat_eff    = lat_legal ? id_latency : LAT_ONE;
    raw_hit    = 1'b0;
    waw_hit    = 1'b0;
    fwd_hit    = 2'b00;
    free_found = 1'b0;
    alloc_oh   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        // rem==1 means the value is already on the memory-stage bus
        if (rem_q[i] != LAT_ONE) begin
          if ((id_uses_ra && reg_q[i] == id_ra) ||
              (id_uses_rb && reg_q[i] == id_rb) ||
              (id_uses_rc && reg_q[i] == id_rc))
            raw_hit = 1'b1;
        end else begin
          if (id_uses_ra && reg_q[i] == id_ra) fwd_hit[0] = 1'b1;
          if (id_uses_rb && reg_q[i] == id_rb) fwd_hit[1] = 1'b1;
        end
        if (reg_q[i] == id_rt && rem_q[i] > lat_eff) waw_hit = 1'b1;
      end
      // an entry retiring on this edge is free for a same-edge allocation
      if (!free_found && (!valid_q[i] || rem_q[i] == LAT_ONE)) begin
        free_found  = 1'b1;
        alloc_oh[i] = 1'b1;
      end
    end
    hazard = raw_hit || (id_writes_rt && (waw_hit || !free_found));
  end

  always_comb begin
    stall          = (state_q == ST_RUN) && id_valid && hazard;
    issue          = (state_q == ST_RUN) && id_valid && !hazard;
    flush          = (state_q == ST_FLUSH);
    branch_fwd_sel = (issue && id_is_branch) ? fwd_hit : 2'b00;
    inflight_count = inflight_q;
  end

  always_comb begin
    valid_d    = '0;
    inflight_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i] && (rem_q[i] != LAT_ONE);
      reg_d[i]   = reg_q[i];
      rem_d[i]   = valid_q[i] ? (rem_q[i] - LAT_ONE) : rem_q[i];
      if (issue && id_writes_rt && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        reg_d[i]   = id_rt;
        rem_d[i]   = lat_eff;
      end
      inflight_d = inflight_d + CNT_W'(valid_d[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (issue && id_is_branch && branch_result) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == FC_W'(1)) state_d = ST_RUN;
        else                    fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fcnt_q     <= '0;
      valid_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= reg_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 16'hFFFF) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

  // illegal latencies are clamped to 1 above; flag them in simulation
  a_lat_legal: assert property (@(posedge clk) disable iff (!reset)
                                (issue && id_writes_rt) |-> lat_legal);

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_hazard_controller
// Brief    : Self-checking bench for decode_hazard_controller (queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_hazard_controller;

  localparam int REG_W        = 7;
  localparam int DEPTH        = 4;
  localparam int LAT_W        = 3;
  localparam int MAX_LAT      = 7;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid, id_uses_ra, id_uses_rb, id_uses_rc;
  logic id_is_branch, id_writes_rt, branch_result;
  logic [REG_W-1:0] id_ra, id_rb, id_rc, id_rt;
  logic [LAT_W-1:0] id_latency;
  logic stall, flush, issue;
  logic [1:0] branch_fwd_sel;
  logic [CNT_W-1:0] inflight_count;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  decode_hazard_controller #(
    .REG_W(REG_W), .DEPTH(DEPTH), .LAT_W(LAT_W),
    .MAX_LAT(MAX_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_ra(id_ra), .id_rb(id_rb), .id_rc(id_rc),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_uses_rc(id_uses_rc),
    .id_is_branch(id_is_branch), .id_writes_rt(id_writes_rt), .id_rt(id_rt),
    .id_latency(id_latency), .branch_result(branch_result),
    .stall(stall), .flush(flush), .issue(issue),
    .branch_fwd_sel(branch_fwd_sel), .inflight_count(inflight_count)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: list of in-flight results ----------
  typedef struct { int rg; int rem; } ent_t;
  ent_t sb[$];
  bit   m_flush = 1'b0;
  int   m_cnt   = 0;
  int   m_count = 0;

  function automatic int eff_lat();
    if (id_latency == 0 || int'(id_latency) > MAX_LAT) return 1;
    return int'(id_latency);
  endfunction

  function automatic void model_eval(output bit es, output bit ei, output bit ef,
                                     output logic [1:0] efw);
    int busy;
    bit haz;
    es = 1'b0; ei = 1'b0; ef = m_flush; efw = 2'b00; busy = 0; haz = 1'b0;
    if (m_flush || !id_valid) return;
    foreach (sb[k]) begin
      bit ha, hb, hc;
      ha = id_uses_ra && (sb[k].rg == int'(id_ra));
      hb = id_uses_rb && (sb[k].rg == int'(id_rb));
      hc = id_uses_rc && (sb[k].rg == int'(id_rc));
      if (sb[k].rem >= 2) begin
        busy++;
        if (ha || hb || hc) haz = 1'b1;
      end else if (id_is_branch) begin
        if (ha) efw[0] = 1'b1;
        if (hb) efw[1] = 1'b1;
      end
      if (id_writes_rt && sb[k].rg == int'(id_rt) && sb[k].rem > eff_lat()) haz = 1'b1;
    end
    if (id_writes_rt && busy >= DEPTH) haz = 1'b1;
    es = haz;
    ei = !haz;
    if (haz) efw = 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin : m_upd
    bit es, ei, ef;
    logic [1:0] efw;
    ent_t nq[$];
    ent_t e;
    if (!reset) begin
      sb.delete();
      m_flush = 1'b0;
      m_cnt   = 0;
      m_count = 0;
    end else begin
      model_eval(es, ei, ef, efw);
      nq.delete();
      foreach (sb[k]) if (sb[k].rem > 1) begin
        e = sb[k];
        e.rem--;
        nq.push_back(e);
      end
      if (ei && id_writes_rt) begin
        e.rg  = int'(id_rt);
        e.rem = eff_lat();
        nq.push_back(e);
      end
      sb = nq;
      if (m_flush) begin
        if (m_cnt == 1) m_flush = 1'b0;
        else            m_cnt--;
      end else if (ei && id_is_branch && branch_result) begin
        m_flush = 1'b1;
        m_cnt   = FLUSH_CYCLES;
      end
      m_count = sb.size();
    end
  end

  always @(negedge clk) begin : cmp
    bit es, ei, ef;
    logic [1:0] efw;
    if (cmp_en && reset) begin
      model_eval(es, ei, ef, efw);
      check("model_stall", stall, es);
      check("model_issue", issue, ei);
      check("model_flush", flush, ef);
      check("model_fwd", branch_fwd_sel, efw);
      check("model_count", inflight_count, m_count);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_ra = 0; id_uses_rb = 0; id_uses_rc = 0;
    id_is_branch = 0; id_writes_rt = 0; branch_result = 0;
    id_ra = '0; id_rb = '0; id_rc = '0; id_rt = '0; id_latency = 3'd1;
  endtask

  task automatic wr(input int rt, input int lat);
    idle();
    id_valid = 1; id_writes_rt = 1;
    id_rt = REG_W'(rt); id_latency = LAT_W'(lat);
  endtask

  task automatic rd(input int ra, input int rb, input bit br, input bit bres);
    idle();
    id_valid = 1; id_is_branch = br; branch_result = bres;
    id_uses_ra = (ra >= 0); id_ra = (ra >= 0) ? REG_W'(ra) : '0;
    id_uses_rb = (rb >= 0); id_rb = (rb >= 0) ? REG_W'(rb) : '0;
  endtask

  task automatic wait_stall_then_issue(input string tag);
    for (int k = 0; k < 4; k++) begin
      #1;
      check({tag, "_stall"}, stall, (k < 3) ? 1 : 0);
      check({tag, "_issue"}, issue, (k == 3) ? 1 : 0);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_issue", issue, 0);
    check("rst_fwd", branch_fwd_sel, 0);
    check("rst_count", inflight_count, 0);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    // asynchronous reset with three results in flight
    tick(); wr(1, 7); #1 check("t1_issue", issue, 1);
    tick(); wr(2, 7);
    tick(); wr(3, 7);
    tick(); rd(1, -1, 0, 0);
    #1 check("t1_count3", inflight_count, 3);
    check("t1_stall_pre", stall, 1);
    #1 reset = 1'b0;
    #1 check("t1_async_count", inflight_count, 0);
    check("t1_async_stall", stall, 0);
    check("t1_async_flush", flush, 0);
    tick(); idle();
    tick(); #1 reset = 1'b1;

    // RAW on a 4-cycle result: three stalls, issue on the fourth
    tick(); wr(5, 4);
    tick(); rd(5, -1, 0, 0);
    wait_stall_then_issue("t2");
    repeat (6) tick();

    // branch operands on the memory-stage bus are forwarded
    tick(); wr(5, 1);
    tick(); rd(5, 6, 1, 0);
    #1 check("t3_stall", stall, 0);
    check("t3_fwd", branch_fwd_sel, 2'b01);
    check("t3_issue", issue, 1);
    tick(); wr(6, 1);
    tick(); rd(9, 6, 1, 0);
    #1 check("t3b_fwd", branch_fwd_sel, 2'b10);
    tick(); wr(8, 1);
    tick(); rd(8, -1, 0, 0);
    #1 check("t3c_fwd_nonbr", branch_fwd_sel, 2'b00);
    check("t3c_issue", issue, 1);
    tick(); idle();

    // WAW: R7 rem=5, new writer lat=2 waits until rem=2
    tick(); wr(7, 5);
    tick(); wr(7, 2);
    wait_stall_then_issue("t4");
    repeat (8) tick();

    // scoreboard full
    tick(); wr(10, 7);
    tick(); wr(11, 7);
    tick(); wr(12, 7);
    tick(); wr(13, 7);
    tick(); wr(14, 3);
    #1 check("full_count", inflight_count, 4);
    #0;
    wait_stall_then_issue("full");
    repeat (9) tick();

    // taken branch: two flush cycles, valid input ignored
    tick(); rd(-1, -1, 1, 1);
    #1 check("t5_issue", issue, 1);
    check("t5_flush0", flush, 0);
    tick(); wr(20, 1);
    #1 check("t5_flush1", flush, 1);
    check("t5_issue1", issue, 0);
    check("t5_stall1", stall, 0);
    tick();
    #1 check("t5_flush2", flush, 1);
    check("t5_count2", inflight_count, 0);
    tick();
    #1 check("t5_run_flush", flush, 0);
    check("t5_run_issue", issue, 1);
    tick(); idle();
    repeat (3) tick();

    // branch_result ignored while stalled
    tick(); wr(21, 4);
    tick(); rd(21, -1, 1, 1);
    #1 check("sb_stall", stall, 1);
    tick(); idle();
    #1 check("sb_noflush", flush, 0);
    repeat (6) tick();

    // reset during flush abandons it
    tick(); rd(-1, -1, 1, 1);
    tick(); idle();
    #1 check("rf_flush", flush, 1);
    #1 reset = 1'b0;
    #1 check("rf_async", flush, 0);
    tick(); #1 reset = 1'b1;
    tick();
    #1 check("rf_run", flush, 0);

`ifdef HAZARD_STATS_EN
    tick(); wr(30, 7); id_uses_ra = 1; id_ra = REG_W'(30);
    repeat (77000) @(posedge clk);
    #1 check("stats_sat", stall_cycles, 16'hFFFF);
    repeat (20) @(posedge clk);
    #1 check("stats_hold", stall_cycles, 16'hFFFF);
    idle();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
